board_ram_arbiter: RTL and testbench

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

---
 rtl/board_ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_board_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares one single-port board RAM between video scan reads,
// a full-board clear sweep and game-logic read/write requests.
module board_ram_arbiter #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CELL = 24,
    parameter int X0   = 100
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [2:0] vid_cell,
    input  logic       g_req,
    input  logic       g_we,
    input  logic [4:0] g_row,
    input  logic [3:0] g_col,
    input  logic [2:0] g_wdata,
    output logic       g_gnt,
    output logic       g_rvalid,
    output logic [2:0] g_rdata,
    output logic       g_err,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    input  logic [2:0] ram_rdata
);

    localparam int         CELLS     = ROWS * COLS;
    localparam logic [7:0] LAST_ADDR = 8'(CELLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sweep_q, sweep_d;
    logic       rd_err_q, rd_err_d;
    logic       vid_slot_q, vid_slot_d;
    logic [2:0] vid_cell_q, vid_cell_d;

    logic       vid_slot;
    logic [7:0] vid_addr;
    logic [7:0] g_addr;
    logic       g_oor;

    // Video reads are issued two pixels ahead of each cell so the latched
    // colour lines up exactly with the cell's first pixel.
    always_comb begin
        vid_slot = 1'b0;
        vid_addr = '0;
        if (DrawY < 10'd480) begin
            for (int k = 0; k < COLS; k++) begin
                if (int'(DrawX) == X0 - 2 + CELL * k) begin
                    vid_slot = 1'b1;
                    vid_addr = 8'((int'(DrawY) / CELL) * COLS + k);
                end
            end
        end
    end

    always_comb begin
        g_addr = 8'(int'(g_row) * COLS + int'(g_col));
        g_oor  = (int'(g_row) >= ROWS) || (int'(g_col) >= COLS);
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        rd_err_d   = rd_err_q;
        vid_slot_d = vid_slot;
        vid_cell_d = vid_slot_q ? ram_rdata : vid_cell_q;
        ram_addr   = vid_slot ? vid_addr : 8'd0;
        ram_we     = 1'b0;
        ram_wdata  = 3'd0;
        g_gnt      = 1'b0;
        g_err      = 1'b0;
        if (Reset_n) begin
            unique case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_d = CLEAR;
                        sweep_d = 8'd0;
                    end else if (g_req && !vid_slot) begin
                        g_gnt     = 1'b1;
                        g_err     = g_oor;
                        ram_addr  = g_addr;
                        ram_we    = g_we && !g_oor;
                        ram_wdata = g_wdata;
                        if (!g_we) begin
                            state_d  = RDWAIT;
                            rd_err_d = g_oor;
                        end
                    end
                end
                CLEAR: begin
                    // Sweep only advances on cycles the video path leaves free.
                    if (!vid_slot) begin
                        ram_addr  = sweep_q;
                        ram_we    = 1'b1;
                        ram_wdata = 3'd0;
                        if (sweep_q == LAST_ADDR) begin
                            state_d = IDLE;
                            sweep_d = 8'd0;
                        end else begin
                            sweep_d = sweep_q + 8'd1;
                        end
                    end
                end
                RDWAIT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            sweep_q    <= 8'd0;
            rd_err_q   <= 1'b0;
            vid_slot_q <= 1'b0;
            vid_cell_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            rd_err_q   <= rd_err_d;
            vid_slot_q <= vid_slot_d;
            vid_cell_q <= vid_cell_d;
        end
    end

    // Read data is passed straight through from the RAM in the wait cycle;
    // out-of-range reads return zero.
    always_comb begin
        vid_cell = vid_cell_q;
        clr_busy = (state_q == CLEAR);
        g_rvalid = (state_q == RDWAIT);
        g_rdata  = (g_rvalid && !rd_err_q) ? ram_rdata : 3'd0;
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: bench-side board RAM, a cycle-level reference
// model checked every negedge, and directed scenarios with literal expectations.
module tb_board_ram_arbiter;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CELL = 24;
    localparam int X0   = 100;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic [2:0] vid_cell;
    logic       g_req, g_we;
    logic [4:0] g_row;
    logic [3:0] g_col;
    logic [2:0] g_wdata;
    logic       g_gnt, g_rvalid, g_err;
    logic [2:0] g_rdata;
    logic       clr_start, clr_busy;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    board_ram_arbiter #(.COLS(COLS), .ROWS(ROWS), .CELL(CELL), .X0(X0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .vid_cell(vid_cell), .g_req(g_req), .g_we(g_we), .g_row(g_row),
        .g_col(g_col), .g_wdata(g_wdata), .g_gnt(g_gnt), .g_rvalid(g_rvalid),
        .g_rdata(g_rdata), .g_err(g_err), .clr_start(clr_start),
        .clr_busy(clr_busy), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    // Single-port board RAM with one-cycle synchronous read.
    logic [2:0] mem [0:255];
    logic [2:0] rdata_q = 3'd0;
    initial for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    always @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rdata_q <= mem[ram_addr];
    end
    assign ram_rdata = rdata_q;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 clearing, 2 read return pending.
    int m_mode = 0, m_sweep = 0, m_vid = 0, m_vpend = 0, m_vval = 0, m_pend = 0;
    int board [0:199];
    initial for (int i = 0; i < 200; i++) board[i] = 0;

    always @(negedge Clk) begin
        int dx, k, slot, vaddr, gaddr, oor, e_gnt, e_we;
        if (!Reset_n) begin
            chk("rst_gnt", g_gnt, 0);
            chk("rst_err", g_err, 0);
            chk("rst_rvalid", g_rvalid, 0);
            chk("rst_rdata", g_rdata, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_vid", vid_cell, 0);
            m_mode = 0; m_sweep = 0; m_vid = 0; m_vpend = 0; m_pend = 0;
        end else begin
            dx    = int'(DrawX) - (X0 - 2);
            slot  = (int'(DrawY) < 480 && dx >= 0 && dx % CELL == 0 && dx / CELL < COLS) ? 1 : 0;
            k     = slot ? dx / CELL : 0;
            vaddr = (int'(DrawY) / CELL) * COLS + k;
            gaddr = int'(g_row) * COLS + int'(g_col);
            oor   = (int'(g_row) >= ROWS || int'(g_col) >= COLS) ? 1 : 0;
            e_gnt = (m_mode == 0 && !clr_start && g_req && !slot) ? 1 : 0;
            e_we  = (!slot && (m_mode == 1 || (e_gnt && g_we && !oor))) ? 1 : 0;

            chk("m_gnt", g_gnt, e_gnt);
            chk("m_err", g_err, e_gnt && oor);
            chk("m_we", ram_we, e_we);
            chk("m_busy", clr_busy, m_mode == 1);
            chk("m_rvalid", g_rvalid, m_mode == 2);
            chk("m_rdata", g_rdata, (m_mode == 2) ? m_pend : 0);
            chk("m_vid", vid_cell, m_vid);
            if (slot) chk("m_addr_vid", ram_addr, vaddr);
            else if (m_mode == 1) chk("m_addr_clr", ram_addr, m_sweep);
            else if (e_gnt && !oor) chk("m_addr_game", ram_addr, gaddr);
            if (e_we) chk("m_wdata", ram_wdata, (m_mode == 1) ? 0 : int'(g_wdata));

            if (m_vpend) m_vid = m_vval;
            m_vpend = slot;
            if (slot) m_vval = board[vaddr];
            if (e_we) board[(m_mode == 1) ? m_sweep : gaddr] = (m_mode == 1) ? 0 : int'(g_wdata);
            case (m_mode)
                0: begin
                    if (clr_start) begin
                        m_mode = 1; m_sweep = 0;
                    end else if (e_gnt && !g_we) begin
                        m_mode = 2; m_pend = oor ? 0 : board[gaddr];
                    end
                end
                1: begin
                    if (!slot) begin
                        if (m_sweep == ROWS * COLS - 1) m_mode = 0;
                        m_sweep++;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    int xpos = 0;
    int ypos = 500;

    task automatic cyc(input int x, input int y);
        @(posedge Clk);
        #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    task automatic step();
        cyc(xpos, ypos);
        xpos++;
    endtask

    task automatic set_req(input bit we, input int row, input int col, input int data);
        g_req = 1'b1; g_we = we; g_row = 5'(row); g_col = 4'(col); g_wdata = 3'(data);
    endtask

    task automatic do_req(input bit we, input int row, input int col, input int data,
                          input bit clr_in_wait);
        int n;
        n = 0;
        step();
        set_req(we, row, col, data);
        #1;
        while (!g_gnt && n < 50) begin
            step();
            #1;
            n++;
        end
        chk("req_grant", g_gnt, 1);
        step();
        g_req = 1'b0;
        if (clr_in_wait) begin
            clr_start = 1'b1;
            step();
            clr_start = 1'b0;
            #1;
            chk("clr_ignored_in_rdwait", clr_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt, n;
        Reset_n = 1'b0; DrawX = 10'd0; DrawY = 10'd500;
        g_req = 1'b1; g_we = 1'b1; g_row = 5'd3; g_col = 4'd7; g_wdata = 3'd5;
        clr_start = 1'b0;
        cyc(0, 500);
        cyc(1, 500);
        #1;
        chk("reset_gnt_gated", g_gnt, 0);
        chk("reset_we", ram_we, 0);
        chk("reset_vid", vid_cell, 0);
        chk("reset_busy", clr_busy, 0);
        g_req = 1'b0;
        cyc(2, 500);
        Reset_n = 1'b1;

        // Game write row 3 col 7 = 5
        cyc(10, 500);
        set_req(1'b1, 3, 7, 5);
        #1;
        chk("wr_gnt", g_gnt, 1);
        chk("wr_addr", ram_addr, 37);
        chk("wr_we", ram_we, 1);
        chk("wr_wdata", ram_wdata, 5);
        cyc(11, 500);
        g_req = 1'b0;

        // Read deferred by video slot k=1
        cyc(122, 0);
        set_req(1'b0, 3, 7, 0);
        #1;
        chk("rd_slot_no_gnt", g_gnt, 0);
        chk("rd_slot_addr", ram_addr, 1);
        cyc(123, 0);
        #1;
        chk("rd_gnt", g_gnt, 1);
        chk("rd_addr", ram_addr, 37);
        chk("rd_we", ram_we, 0);
        cyc(124, 0);
        g_req = 1'b0;
        #1;
        chk("rd_rvalid", g_rvalid, 1);
        chk("rd_rdata", g_rdata, 5);

        // Video fetch of cell 25
        cyc(10, 500);
        set_req(1'b1, 2, 5, 4);
        cyc(11, 500);
        g_req = 1'b0;
        for (int x = 210; x <= 250; x++) begin
            cyc(x, 50);
            #1;
            if (x == 218) chk("vid_addr25", ram_addr, 25);
            if (x == 220) chk("vid_first_px", vid_cell, 4);
            if (x == 243) chk("vid_last_px", vid_cell, 4);
            if (x == 246) chk("vid_next_cell", vid_cell, 0);
        end

        // Out-of-range read
        cyc(10, 500);
        set_req(1'b0, 20, 0, 0);
        #1;
        chk("oor_gnt", g_gnt, 1);
        chk("oor_err", g_err, 1);
        chk("oor_we", ram_we, 0);
        cyc(11, 500);
        g_req = 1'b0;
        #1;
        chk("oor_rvalid", g_rvalid, 1);
        chk("oor_rdata", g_rdata, 0);

        // Full clear with a pending write competing
        cyc(0, 500);
        clr_start = 1'b1;
        set_req(1'b1, 1, 1, 6);
        #1;
        chk("clr_beats_req", g_gnt, 0);
        busy_cnt = 0;
        for (int i = 1; i < 400; i++) begin
            cyc(i, 500);
            clr_start = 1'b0;
            #1;
            if (!clr_busy) break;
            if (ram_addr != 8'(busy_cnt) || !ram_we || g_gnt) begin
                chk("clr_sweep_addr", ram_addr, busy_cnt);
                chk("clr_sweep_we", ram_we, 1);
                chk("clr_sweep_no_gnt", g_gnt, 0);
            end
            busy_cnt++;
        end
        chk("clr_busy_cycles", busy_cnt, 200);
        chk("clr_pending_gnt", g_gnt, 1);
        chk("clr_pending_addr", ram_addr, 11);
        cyc(450, 500);
        g_req = 1'b0;
        cyc(460, 500);
        set_req(1'b0, 3, 7, 0);
        cyc(461, 500);
        g_req = 1'b0;
        #1;
        chk("clr_cell37_zero", g_rdata, 0);

        // Reset in the middle of a sweep
        cyc(0, 500);
        clr_start = 1'b1;
        n = 0;
        for (int i = 1; i < 100; i++) begin
            cyc(i, 500);
            clr_start = 1'b0;
            #1;
            n = i;
            if (clr_busy && ram_addr == 8'd50) break;
        end
        chk("mid_clr_reached", ram_addr, 50);
        Reset_n = 1'b0;
        #1;
        chk("mid_clr_busy_drop", clr_busy, 0);
        chk("mid_clr_we_drop", ram_we, 0);
        cyc(n + 1, 500);
        Reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(n + 2 + i, 500);
            #1;
            if (ram_we || clr_busy) begin
                chk("post_rst_we", ram_we, 0);
                chk("post_rst_busy", clr_busy, 0);
            end
        end

        // Mixed traffic across a video line (row 1)
        xpos = 60;
        ypos = 30;
        do_req(1'b1, 1, 2, 7, 1'b0);
        do_req(1'b1, 1, 0, 3, 1'b0);
        do_req(1'b0, 1, 2, 0, 1'b1);
        do_req(1'b1, 5, 12, 2, 1'b0);
        do_req(1'b0, 19, 9, 0, 1'b0);
        while (xpos < 340) begin
            step();
            #1;
            if (DrawX == 10'd110) chk("mix_vid_c10", vid_cell, 3);
            if (DrawX == 10'd150) chk("mix_vid_c12", vid_cell, 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
